// File: rtl/iob_axi_burst_wr_pkg.sv
// ============================================================================
// iob_axi_burst_wr_pkg
// Shared AXI encodings and FSM state type for the AXI write-burst engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package iob_axi_burst_wr_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
  localparam logic [3:0] AXI_QOS_DEFAULT   = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iob_axi_wdata_buf.sv
// ============================================================================
// iob_axi_wdata_buf
// One-entry {data,strb} holding register; load and drain may occur together.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_axi_wdata_buf #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic                drain_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] strb_i,
  output logic                full_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [DATA_W/8-1:0] strb_o
);

  logic                full_q, full_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;

  // A same-cycle reload wins over the drain so the entry stays full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    strb_d = strb_q;
    if (drain_i) full_d = 1'b0;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
      strb_d = strb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign strb_o = strb_q;

endmodule

`default_nettype wire

// File: rtl/iob_axi_burst_wr.sv
// ============================================================================
// iob_axi_burst_wr
// Drains a native read port into a single AXI4 INCR write burst per run.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_axi_burst_wr
  import iob_axi_burst_wr_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = ADDR_W,
  parameter int AXI_DATA_W = DATA_W,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    run_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [AXI_LEN_W-1:0]    length_i,
  output logic                    ready_o,
  output logic                    error_o,
  output logic                    m_valid_o,
  output logic [ADDR_W-1:0]       m_addr_o,
  input  logic [DATA_W-1:0]       m_rdata_i,
  input  logic [DATA_W/8-1:0]     m_rstrb_i,
  input  logic                    m_ready_i,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int CNT_W      = AXI_LEN_W + 1;
  localparam int BEAT_SHIFT = $clog2(DATA_W / 8);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]     fetched_q, fetched_d;
  logic [CNT_W-1:0]     sent_q, sent_d;
  logic                 error_q, error_d;

  logic [CNT_W-1:0]     len_ext;
  logic                 in_data;
  logic                 buf_full;
  logic                 buf_drain;
  logic                 fetch_hs;
  logic                 w_hs;
  logic [DATA_W-1:0]    buf_data;
  logic [DATA_W/8-1:0]  buf_strb;
  logic                 unused_bid;

  assign len_ext   = {1'b0, len_q};
  assign in_data   = (state_q == ST_DATA);
  assign buf_drain = in_data & buf_full & m_axi_wready;
  // Fetch may refill the buffer in the same cycle it drains, giving 1 beat/clk.
  assign m_valid_o = in_data & (fetched_q <= len_ext) & (~buf_full | buf_drain);
  assign m_addr_o  = addr_q + (ADDR_W'(fetched_q) << BEAT_SHIFT);
  assign fetch_hs  = m_valid_o & m_ready_i;
  assign w_hs      = m_axi_wvalid & m_axi_wready;

  iob_axi_wdata_buf #(
    .DATA_W (DATA_W)
  ) u_wdata_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (fetch_hs),
    .drain_i (buf_drain),
    .data_i  (m_rdata_i),
    .strb_i  (m_rstrb_i),
    .full_o  (buf_full),
    .data_o  (buf_data),
    .strb_o  (buf_strb)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    fetched_d = fetched_q;
    sent_d    = sent_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          addr_d    = addr_i;
          len_d     = length_i;
          fetched_d = '0;
          sent_d    = '0;
          error_d   = 1'b0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fetch_hs) fetched_d = fetched_q + CNT_W'(1);
        if (w_hs) begin
          sent_d = sent_q + CNT_W'(1);
          if (m_axi_wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY) error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      fetched_q <= '0;
      sent_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      fetched_q <= fetched_d;
      sent_q    <= sent_d;
      error_q   <= error_d;
    end
  end

  assign ready_o       = (state_q == ST_IDLE);
  assign error_o       = error_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = AXI_ADDR_W'(addr_q);
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(BEAT_SHIFT);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = AXI_PROT_DEFAULT;
  assign m_axi_awqos   = AXI_QOS_DEFAULT;
  assign m_axi_awvalid = (state_q == ST_ADDR);

  assign m_axi_wdata   = buf_data;
  assign m_axi_wstrb   = buf_strb;
  assign m_axi_wlast   = (sent_q == len_ext);
  assign m_axi_wvalid  = in_data & buf_full;

  assign m_axi_bready  = (state_q == ST_RESP);

  assign unused_bid    = ^m_axi_bid;

endmodule

`default_nettype wire

// File: tb/tb_iob_axi_burst_wr.sv
// ============================================================================
// tb_iob_axi_burst_wr
// Directed, table-driven bench for the AXI write-burst engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iob_axi_burst_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [7:0]  length_i = '0;
  logic        ready_o, error_o, m_valid_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_rdata_i;
  logic [3:0]  m_rstrb_i;
  logic        m_ready_i = 1'b1;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic        awlock, awvalid;
  logic [3:0]  awcache, awqos;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready = 1'b0;
  logic [0:0]  bid = '0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Fetched data is a fixed function of the address, so order errors show up.
  assign m_rdata_i = m_addr_o ^ 32'hC0DE_0000;
  assign m_rstrb_i = m_addr_o[5:2] ^ 4'hF;

  iob_axi_burst_wr dut (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run_i), .addr_i(addr_i), .length_i(length_i),
    .ready_o(ready_o), .error_o(error_o), .m_valid_o(m_valid_o), .m_addr_o(m_addr_o),
    .m_rdata_i(m_rdata_i), .m_rstrb_i(m_rstrb_i), .m_ready_i(m_ready_i),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    bit          tog;
    logic [1:0]  bresp;
    int          awdly;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ready"}, {63'd0, ready_o}, 64'd1);
    chk({name, "_valids"}, {60'd0, awvalid, wvalid, m_valid_o, bready}, 64'd0);
  endtask

  task automatic start_aw(input vec_t v);
    @(negedge clk);
    addr_i = v.addr; length_i = v.len; run_i = 1'b1;
    @(negedge clk);
    if (v.awdly == 0) run_i = 1'b0;
    else begin
      addr_i = 32'hDEAD_0000; length_i = 8'h55;
    end
    #1;
    chk("aw_valid", {63'd0, awvalid}, 64'd1);
    chk("aw_addr", {32'd0, awaddr}, {32'd0, v.addr});
    chk("aw_len", {56'd0, awlen}, {56'd0, v.len});
    chk("aw_fixed", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
        {1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    chk("err_cleared", {62'd0, error_o, ready_o}, 64'd0);
    for (int d = 0; d < v.awdly; d++) begin
      @(negedge clk); #1;
      chk("aw_wait", {61'd0, m_valid_o, wvalid, awvalid}, 64'd1);
      chk("aw_hold", {32'd0, awaddr}, {32'd0, v.addr});
    end
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0; run_i = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int beats = 0, fetches = 0, cyc = 0, first_w = -1, last_w = 0;
    bit done = 0, stalled = 0;
    logic [31:0] a, hold_d;
    logic [3:0]  hold_s;
    start_aw(v);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      wready = v.tog ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (stalled && wvalid) begin
        chk("stall_hold", {28'd0, wstrb, wdata}, {28'd0, hold_s, hold_d});
      end
      stalled = wvalid && !wready;
      hold_d = wdata; hold_s = wstrb;
      if (m_valid_o && m_ready_i) begin
        chk("m_addr", {32'd0, m_addr_o}, {32'd0, v.addr + 32'(fetches * 4)});
        fetches++;
      end
      if (wvalid && wready) begin
        a = v.addr + 32'(beats * 4);
        chk("wdata", {32'd0, wdata}, {32'd0, a ^ 32'hC0DE_0000});
        chk("wstrb", {60'd0, wstrb}, {60'd0, a[5:2] ^ 4'hF});
        chk("wlast", {63'd0, wlast}, {63'd0, beats == int'(v.len)});
        if (first_w < 0) first_w = cyc;
        last_w = cyc;
        beats++;
        if (wlast) done = 1;
      end
      cyc++;
    end
    if (!done) chk("w_timeout", 64'd0, 64'd1);
    chk("beats", 64'(beats), 64'(int'(v.len) + 1));
    chk("fetches", 64'(fetches), 64'(int'(v.len) + 1));
    if (!v.tog) chk("b2b", 64'(last_w - first_w), 64'(v.len));
    @(negedge clk);
    wready = 1'b0;
    #1;
    chk("resp_state", {61'd0, bready, wvalid, m_valid_o}, 64'd4);
    bvalid = 1'b1; bresp = v.bresp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    chk("done_ready", {63'd0, ready_o}, 64'd1);
    chk("error", {63'd0, error_o}, {63'd0, v.exp_err});
  endtask

  initial begin
    int wbeats;
    vec_t r;
    vecs[0] = '{32'h0000_0100, 8'd3,   1'b0, 2'b00, 0, 1'b0};
    vecs[1] = '{32'h0000_0200, 8'd0,   1'b0, 2'b00, 0, 1'b0};
    vecs[2] = '{32'h0000_0400, 8'd7,   1'b1, 2'b00, 0, 1'b0};
    vecs[3] = '{32'h0000_0040, 8'd1,   1'b0, 2'b10, 0, 1'b1};
    vecs[4] = '{32'h0000_0080, 8'd2,   1'b0, 2'b00, 0, 1'b0};
    vecs[5] = '{32'h0000_0300, 8'd3,   1'b0, 2'b00, 5, 1'b0};
    vecs[6] = '{32'h0000_1000, 8'd255, 1'b0, 2'b00, 0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset_err", {63'd0, error_o}, 64'd0);

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Reset while beat 2 of 4 is handed over, then a fresh burst.
    r = '{32'h0000_0500, 8'd3, 1'b0, 2'b00, 0, 1'b0};
    start_aw(r);
    wbeats = 0;
    for (int c = 0; c < 50 && wbeats < 2; c++) begin
      @(negedge clk);
      wready = 1'b1;
      #1;
      if (wvalid) wbeats++;
    end
    chk("pre_reset_beats", 64'(wbeats), 64'd2);
    @(negedge clk);
    rst_n = 1'b0; wready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("mid_reset");
    run_burst('{32'h0000_0600, 8'd1, 1'b0, 2'b00, 0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
